// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path: frame state encoding,
// parity-type codes and serial line levels.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity bit for a payload word; odd parity inverts the
// plain XOR reduction so the total count of ones comes out odd.
module uart_parity_calc
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] DATA,
  input  logic                  PAR_TYP,
  output logic                  PAR_BIT
);

  assign PAR_BIT = (PAR_TYP == PAR_ODD) ? ~(^DATA) : (^DATA);

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame controller: accepts a byte in IDLE, then sequences
// START, DATA (via the external serializer), optional PARITY and STOP.
module uart_tx_frame_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  ARSTn,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_data,
  input  logic                  ser_done,
  output logic                  ser_en,
  output logic [DATA_WIDTH-1:0] ser_word,
  output logic                  TX_OUT,
  output logic                  busy
);

  state_t state_reg;
  logic   par_en_reg;
  logic   par_bit_reg;
  logic   par_bit_next;

  uart_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .DATA    (P_DATA),
    .PAR_TYP (PAR_TYP),
    .PAR_BIT (par_bit_next)
  );

  // Parity type is folded into par_bit_reg at acceptance, so only the enable is kept.
  always_ff @(posedge clk or negedge ARSTn) begin
    if (!ARSTn) begin
      state_reg   <= IDLE;
      ser_word    <= '0;
      par_en_reg  <= 1'b0;
      par_bit_reg <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (DATA_VALID) begin
            state_reg   <= START;
            ser_word    <= P_DATA;
            par_en_reg  <= PAR_EN;
            par_bit_reg <= par_bit_next;
          end
        end
        START:  state_reg <= DATA;
        DATA: begin
          if (ser_done) state_reg <= par_en_reg ? PARITY : STOP;
        end
        PARITY: state_reg <= STOP;
        STOP:   state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Moore decode; DATA passes the serializer bit straight through.
  always_comb begin
    TX_OUT = LINE_IDLE;
    busy   = 1'b0;
    ser_en = 1'b0;
    unique case (state_reg)
      IDLE: begin
        TX_OUT = LINE_IDLE;
      end
      START: begin
        TX_OUT = START_BIT;
        busy   = 1'b1;
        ser_en = 1'b1;
      end
      DATA: begin
        TX_OUT = ser_data;
        busy   = 1'b1;
        ser_en = 1'b1;
      end
      PARITY: begin
        TX_OUT = par_bit_reg;
        busy   = 1'b1;
      end
      STOP: begin
        TX_OUT = STOP_BIT;
        busy   = 1'b1;
      end
      default: begin
        TX_OUT = LINE_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Scoreboard bench for uart_tx_frame_ctrl with an attached serializer model;
// expected line bits are queued at acceptance and compared every busy cycle.
module tb_uart_tx_frame_ctrl;
  localparam int W  = 8;
  localparam int IW = $clog2(W);

  logic         clk = 1'b0;
  logic         arstn;
  logic [W-1:0] p_data;
  logic         dv;
  logic         par_en;
  logic         par_typ;
  logic         ser_data;
  logic         ser_done;
  logic         ser_en;
  logic [W-1:0] ser_word;
  logic         tx_out;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_frame_ctrl #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .ARSTn      (arstn),
    .P_DATA     (p_data),
    .DATA_VALID (dv),
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
    .ser_data   (ser_data),
    .ser_done   (ser_done),
    .ser_en     (ser_en),
    .ser_word   (ser_word),
    .TX_OUT     (tx_out),
    .busy       (busy)
  );

  // Serializer model: index parks at W-1 while disabled, wraps to 0 when enabled.
  logic [IW-1:0] idx;
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn)                   idx <= IW'(W - 1);
    else if (!ser_en)             idx <= IW'(W - 1);
    else if (idx == IW'(W - 1))   idx <= '0;
    else                          idx <= idx + 1'b1;
  end
  assign ser_data = ser_word[idx];
  assign ser_done = (idx == IW'(W - 1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic tx;
    logic en;
  } exp_t;

  exp_t         q[$];
  int           m_left;
  logic [W-1:0] m_word;
  logic         mon_on = 1'b0;

  function automatic void push_frame(input logic [W-1:0] d, input logic en, input logic typ);
    exp_t e;
    e.tx = 1'b0; e.en = 1'b1; q.push_back(e);
    for (int i = 0; i < W; i++) begin
      e.tx = d[i]; e.en = 1'b1; q.push_back(e);
    end
    if (en) begin
      e.tx = (^d) ^ typ; e.en = 1'b0; q.push_back(e);
    end
    e.tx = 1'b1; e.en = 1'b0; q.push_back(e);
  endfunction

  // Reference timing: m_left counts remaining busy cycles of the current frame.
  always @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      q.delete();
      m_left <= 0;
      m_word <= '0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
    end else if (dv) begin
      push_frame(p_data, par_en, par_typ);
      m_left <= 2 + W + int'(par_en);
      m_word <= p_data;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (mon_on && arstn) begin
      chk("busy", busy, m_left > 0);
      if (m_left > 0) begin
        if (q.size() == 0) begin
          chk("q_underrun", 1, 0);
        end else begin
          e = q.pop_front();
          chk("tx", tx_out, e.tx);
          chk("ser_en", ser_en, e.en);
          chk("ser_word", ser_word, m_word);
        end
      end else begin
        chk("tx_idle", tx_out, 1);
        chk("ser_en_idle", ser_en, 0);
        chk("ser_word_hold", ser_word, m_word);
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input logic en, input logic typ);
    @(negedge clk);
    p_data = d; par_en = en; par_typ = typ; dv = 1'b1;
    @(negedge clk);
    dv = 1'b0;
  endtask

  task automatic drain(input int n);
    repeat (n) @(negedge clk);
    chk("q_empty", q.size(), 0);
  endtask

  initial begin
    arstn = 1'b0; p_data = '0; dv = 1'b0; par_en = 1'b0; par_typ = 1'b0;
    #1;
    chk("rst_tx", tx_out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ser_en", ser_en, 0);
    chk("rst_ser_word", ser_word, 0);
    repeat (2) @(negedge clk);
    #2 arstn = 1'b1;
    mon_on = 1'b1;

    // Reset mid-DATA takes effect immediately.
    send(8'h5A, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    #2 arstn = 1'b0;
    #1;
    chk("arst_tx", tx_out, 1);
    chk("arst_busy", busy, 0);
    chk("arst_ser_en", ser_en, 0);
    repeat (2) @(negedge clk);
    #2 arstn = 1'b1;
    drain(5);

    send(8'hA5, 1'b1, 1'b0);   // even parity
    drain(12);
    send(8'hA5, 1'b1, 1'b1);   // odd parity
    drain(12);
    send(8'h01, 1'b0, 1'b0);   // no parity
    drain(11);

    // DATA_VALID held high, payload changed mid-frame.
    @(negedge clk);
    p_data = 8'h3C; par_en = 1'b0; par_typ = 1'b0; dv = 1'b1;
    repeat (5) @(negedge clk);
    p_data = 8'hFF;
    repeat (9) @(negedge clk);
    dv = 1'b0;
    drain(12);

    // Input toggles while busy must not alter or restart the frame.
    @(negedge clk);
    p_data = 8'hA5; par_en = 1'b1; par_typ = 1'b0; dv = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      dv      = i[0];
      par_en  = ~par_en;
      par_typ = 1'($urandom);
      p_data  = 8'($urandom);
    end
    @(negedge clk);
    dv = 1'b0;
    drain(8);

    // Randomised frames back through the scoreboard.
    for (int n = 0; n < 6; n++) begin
      send(8'($urandom), 1'($urandom), 1'($urandom));
      drain(12);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame_ctrl.md
Name: uart_tx_frame_ctrl

Overview:
- Frame controller for the UART transmit path. Sits directly upstream of the TX serializer stage: it drives `ser_en` and the held parallel word, and consumes `ser_data` / `ser_done`.
- Accepts a parallel byte via a valid strobe, latches it with the parity config, and sequences the line through START, DATA, optional PARITY and STOP.
- Muxes the result onto `TX_OUT`. One frame bit per `clk`, where `clk` is the TX bit clock.

Parameters:
- DATA_WIDTH, 8, payload bits per frame; must match the serializer width.

Ports:
- clk  in  1  TX bit clock; all state changes on its rising edge.
- ARSTn  in  1  asynchronous reset, active-low.
- P_DATA  in  DATA_WIDTH  parallel payload; sampled only on acceptance.
- DATA_VALID  in  1  payload-valid strobe; level-sampled in IDLE.
- PAR_EN  in  1  1 = append parity bit; sampled on acceptance.
- PAR_TYP  in  1  0 = even, 1 = odd; sampled on acceptance.
- ser_data  in  1  current data bit from the serializer.
- ser_done  in  1  serializer at last-bit index (also high when idle).
- ser_en  out  1  serializer enable.
- ser_word  out  DATA_WIDTH  latched payload held for the serializer.
- TX_OUT  out  1  serial line; idle-high.
- busy  out  1  high from the START bit through the STOP bit inclusive.

Behaviour:
- Reset (asynchronous, immediate, including mid-frame):
  - state = IDLE, `ser_word` = 0, parity register = 0.
  - `TX_OUT` = 1, `busy` = 0, `ser_en` = 0.
- States: IDLE, START, DATA, PARITY, STOP; encoding from the shared package.
- Outputs are pure Moore decodes of the registered state:
  - IDLE: `TX_OUT` = 1, `busy` = 0, `ser_en` = 0.
  - START: `TX_OUT` = 0, `busy` = 1, `ser_en` = 1.
  - DATA: `TX_OUT` = `ser_data`, `busy` = 1, `ser_en` = 1.
  - PARITY: `TX_OUT` = parity register, `busy` = 1, `ser_en` = 0.
  - STOP: `TX_OUT` = 1, `busy` = 1, `ser_en` = 0.
- Transitions:
  - IDLE → START when `DATA_VALID` = 1 at the edge. On that same edge: `ser_word` <= `P_DATA`, parity config latched, parity register <= `^P_DATA ^ PAR_TYP`.
  - START → DATA unconditionally after 1 cycle.
  - DATA → (PARITY if latched `PAR_EN`, else STOP) when `ser_done` = 1. Otherwise stay in DATA.
  - PARITY → STOP after 1 cycle.
  - STOP → IDLE after 1 cycle.
- Serializer contract:
  - Serializer index sits at DATA_WIDTH-1 while `ser_en` = 0.
  - Asserting `ser_en` in START moves the index to 0 at the START→DATA edge, so DATA cycle k presents bit k (LSB first).
  - `ser_done` during DATA marks bit DATA_WIDTH-1.
  - `ser_done` is ignored in all states other than DATA.
- Latency: `TX_OUT` falls exactly 1 cycle after the accepting edge.
- Frame length: 1 + DATA_WIDTH + PAR_EN + 1 cycles of `busy`.
- Minimum spacing: ≥1 IDLE cycle between frames. Back-to-back `DATA_VALID` yields exactly one idle-high bit between consecutive STOP and START.
- `DATA_VALID`, `P_DATA`, `PAR_EN` and `PAR_TYP` are ignored whenever state ≠ IDLE. Changes mid-frame have no effect on the current frame.
- `DATA_VALID` held high continuously → a new frame every 2 + DATA_WIDTH + PAR_EN + 1 cycles.
- `ser_word` holds its value after the frame until the next acceptance.

Decomposition:
- Shared package `uart_tx_pkg`:
  - 3-bit state localparams: IDLE = 0, START = 1, DATA = 2, PARITY = 3, STOP = 4.
  - PAR_EVEN = 0, PAR_ODD = 1.
  - Line levels: LINE_IDLE = 1, START_BIT = 0, STOP_BIT = 1.
- Sub-module `uart_parity_calc` (parameter DATA_WIDTH):
  - Combinational; `DATA` and `PAR_TYP` in, `PAR_BIT` out.
  - Instantiated on `P_DATA`; its result is registered on acceptance.
- FSM, output mux and latches stay in `uart_tx_frame_ctrl`.

Test Plan:
1. Reset sequence: assert `ARSTn` = 0 mid-DATA of a frame → same instant `TX_OUT` = 1, `busy` = 0, `ser_en` = 0. Release, then idle 5 cycles → `TX_OUT` remains 1.
2. `P_DATA` = 0xA5, `PAR_EN` = 1, `PAR_TYP` = 0, 1-cycle `DATA_VALID` (bench serializer model attached) → `TX_OUT` over 11 cycles = 0,1,0,1,0,0,1,0,1,0,1; `busy` high for exactly 11 cycles.
3. `P_DATA` = 0xA5, `PAR_EN` = 1, `PAR_TYP` = 1 → parity cycle (cycle 10) `TX_OUT` = 1, then stop = 1.
4. `P_DATA` = 0x01, `PAR_EN` = 0 → 10-cycle frame 0,1,0,0,0,0,0,0,0,1. No parity state visited; `ser_en` high for exactly 9 cycles.
5. `DATA_VALID` held high with `P_DATA` = 0x3C then changed to 0xFF mid-frame → first frame carries 0x3C. Exactly 1 idle-high cycle follows, then a second frame carrying 0xFF.
6. Mid-frame toggles of `DATA_VALID`, `PAR_EN` and `PAR_TYP` while `busy` = 1 → frame bits unchanged from the values latched at acceptance; no extra frame is started.
